// File: rtl/sbm_digit_scheduler.sv
// Shares one digit-serial multiplier unit between NREQ requesters (round-robin).
// Optional SBM_SCHED_SKIP_ZERO_EN: all-zero b digits bypass the unit.
module sbm_digit_scheduler #(
    parameter int SIZEA         = 521,
    parameter int SIZEB         = 521,
    parameter int SIZEOF_DIGITS = 32,
    parameter int DIGITS        = 17,
    parameter int NREQ          = 2,
    parameter int IDW           = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*SIZEA-1:0]           a_in,
    input  logic [NREQ*SIZEB-1:0]           b_in,
    output logic [NREQ-1:0]                 gnt,
    output logic                            busy,
    output logic [SIZEA-1:0]                unit_a,
    output logic [SIZEOF_DIGITS-1:0]        unit_b,
    output logic                            unit_start,
    output logic                            unit_clr,
    input  logic [SIZEA+SIZEOF_DIGITS-1:0]  unit_c,
    input  logic                            unit_done,
    output logic [SIZEA+SIZEB-1:0]          c,
    output logic                            c_valid,
    output logic [IDW-1:0]                  c_id
);

    localparam int CW  = SIZEA + SIZEB;
    localparam int BXW = DIGITS * SIZEOF_DIGITS;
    localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_ACC, S_CLR, S_DONE
    } state_t;

    state_t                   r_state;
    logic [SIZEA-1:0]         r_a;
    logic [SIZEB-1:0]         r_b;
    logic [IDW-1:0]           r_id;
    logic [IDW-1:0]           r_rr;
    logic [DGW-1:0]           r_digit;
    logic [CW-1:0]            r_acc;
    logic [NREQ-1:0]          r_gnt;
    logic                     r_busy;
    logic                     r_unit_start;
    logic                     r_unit_clr;
    logic [CW-1:0]            r_c;
    logic                     r_c_valid;
    logic [IDW-1:0]           r_c_id;

    logic [BXW-1:0]           w_bx;
    logic [SIZEOF_DIGITS-1:0] w_digit;
    logic                     w_last;
    logic [CW-1:0]            w_addend;
    logic                     w_any;
    logic [IDW-1:0]           w_sel;
    logic                     w_skip_cur;
    logic                     w_skip_nxt;
    logic                     w_skip_first;

    // b is zero-extended to a whole number of digits
    assign w_bx    = BXW'(r_b);
    assign w_digit = w_bx[int'(r_digit)*SIZEOF_DIGITS +: SIZEOF_DIGITS];
    assign w_last  = (r_digit == DGW'(DIGITS-1));

`ifdef SBM_SCHED_SKIP_ZERO_EN
    logic [SIZEOF_DIGITS-1:0] w_nxt_digit;
    logic [SIZEOF_DIGITS-1:0] w_first_digit;
    assign w_nxt_digit   = SIZEOF_DIGITS'(w_bx >> (SIZEOF_DIGITS*(int'(r_digit)+1)));
    assign w_first_digit = b_in[int'(w_sel)*SIZEB +: SIZEOF_DIGITS];
    assign w_skip_cur    = (w_digit == '0);
    assign w_skip_nxt    = (w_nxt_digit == '0);
    assign w_skip_first  = (w_first_digit == '0);
`else
    assign w_skip_cur    = 1'b0;
    assign w_skip_nxt    = 1'b0;
    assign w_skip_first  = 1'b0;
`endif

    assign w_addend = w_skip_cur ? '0
                    : (CW'(unit_c) << (int'(r_digit)*SIZEOF_DIGITS));

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && req[(int'(r_rr)+k) % NREQ]) begin
                w_any = 1'b1;
                w_sel = IDW'((int'(r_rr)+k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            r_rr         <= '0;
            r_digit      <= '0;
            r_acc        <= '0;
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_unit_start <= 1'b0;
            r_unit_clr   <= 1'b0;
            r_c          <= '0;
            r_c_valid    <= 1'b0;
            r_c_id       <= '0;
        end else begin
            r_gnt      <= '0;
            r_unit_clr <= 1'b0;
            r_c_valid  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= NREQ'(1) << w_sel;
                        r_a        <= a_in[int'(w_sel)*SIZEA +: SIZEA];
                        r_b        <= b_in[int'(w_sel)*SIZEB +: SIZEB];
                        r_id       <= w_sel;
                        r_acc      <= '0;
                        r_digit    <= '0;
                        r_busy     <= 1'b1;
                        r_unit_clr <= ~w_skip_first;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_unit_start <= ~w_skip_cur;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    if (w_skip_cur || unit_done) begin
                        r_unit_start <= 1'b0;
                        r_state      <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + w_addend;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_digit <= r_digit + 1'b1;
                        // a zero next digit goes straight to RUN without clearing the unit
                        if (w_skip_nxt) begin
                            r_state <= S_RUN;
                        end else begin
                            r_unit_clr <= 1'b1;
                            r_state    <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    r_unit_start <= 1'b1;
                    r_state      <= S_RUN;
                end
                S_DONE: begin
                    r_c       <= r_acc;
                    r_c_id    <= r_id;
                    r_c_valid <= 1'b1;
                    r_rr      <= IDW'((int'(r_id)+1) % NREQ);
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign unit_a     = r_a;
    assign unit_b     = w_digit;
    assign unit_start = r_unit_start;
    assign unit_clr   = r_unit_clr;
    assign c          = r_c;
    assign c_valid    = r_c_valid;
    assign c_id       = r_c_id;

endmodule
